// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: start control, decode feedback, instruction ROM bus and
// decode-facing outputs. The fetch unit uses the master modport.
interface instr_fetch_if #(
   parameter int PC_W  = 10,
   parameter int IW    = 9,
   parameter int CNT_W = 16
);
   logic              Start;
   logic [PC_W-1:0]   StartAddr;
   logic              Stall;
   logic              Branch;
   logic              BranchTaken;
   logic [PC_W-1:0]   Target;
   logic              HaltReq;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_en;
   logic [IW-1:0]     imem_data;
   logic [IW-1:0]     Instr;
   logic              Valid;
   logic [PC_W-1:0]   PC;
   logic              Done;
   logic [CNT_W-1:0]  InstrCount;
   logic [CNT_W-1:0]  CycleCount;
   logic [1:0]        dbg_state;

   // Valid/Stall: an instruction is consumed by decode on a cycle where
   // Valid=1 and Stall=0; with Stall=1 Instr, PC and Valid hold steady.
   modport master (
      input  Start, StartAddr, Stall, Branch, BranchTaken, Target, HaltReq,
             imem_data,
      output imem_addr, imem_en, Instr, Valid, PC, Done, InstrCount,
             CycleCount, dbg_state
   );

   modport slave (
      output Start, StartAddr, Stall, Branch, BranchTaken, Target, HaltReq,
             imem_data,
      input  imem_addr, imem_en, Instr, Valid, PC, Done, InstrCount,
             CycleCount, dbg_state
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous ROM addressing, branch squash,
// stall, halt and start. FETCH_PERF_EN adds retired-instruction/RUN-cycle counters.
module instr_fetch #(
   parameter int PC_W  = 10,
   parameter int IW    = 9,
   parameter int CNT_W = 16
) (
   input  logic           Clk,
   input  logic           Reset,
   instr_fetch_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              squash_q, squash_d;
   logic              done_q, done_d;
   logic              imem_en;
   logic              valid;
   logic              start_accept;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= '0;
         pc_q       <= '0;
         squash_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
         squash_q   <= squash_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      pc_d         = pc_q;
      squash_d     = squash_q;
      done_d       = done_q;
      imem_en      = 1'b0;
      valid        = 1'b0;
      start_accept = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (bus.Start) begin
               start_accept = 1'b1;
               fetch_pc_d   = bus.StartAddr;
               done_d       = 1'b0;
               squash_d     = 1'b0;
               state_d      = S_PRIME;
            end
         end
         S_PRIME: begin
            imem_en    = 1'b1;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_W'(1);
            state_d    = S_RUN;
         end
         S_RUN: begin
            valid = !squash_q;
            if (!bus.Stall) begin
               if (valid && bus.HaltReq) begin
                  state_d = S_HALT;
                  done_d  = 1'b1;
               end else if (valid && bus.Branch && bus.BranchTaken) begin
                  // The word read this cycle is wrong-path; squash marks it so
                  // the following cycle is a bubble and PC keeps its value.
                  imem_en    = 1'b1;
                  fetch_pc_d = bus.Target;
                  squash_d   = 1'b1;
               end else begin
                  imem_en    = 1'b1;
                  pc_d       = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + PC_W'(1);
                  squash_d   = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.imem_addr = fetch_pc_q;
   assign bus.imem_en   = imem_en;
   assign bus.Instr     = bus.imem_data;
   assign bus.Valid     = valid;
   assign bus.PC        = pc_q;
   assign bus.Done      = done_q;
   assign bus.dbg_state = state_q;

`ifdef FETCH_PERF_EN
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         instr_cnt_q <= '0;
         cycle_cnt_q <= '0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   always_comb begin
      instr_cnt_d = instr_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      if (start_accept) begin
         instr_cnt_d = '0;
         cycle_cnt_d = '0;
      end else if (state_q == S_RUN) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
         if (valid && !bus.Stall) instr_cnt_d = instr_cnt_q + CNT_W'(1);
      end
   end

   assign bus.InstrCount = instr_cnt_q;
   assign bus.CycleCount = cycle_cnt_q;
`else
   logic unused_start_accept;
   assign unused_start_accept = start_accept;
   assign bus.InstrCount = '0;
   assign bus.CycleCount = '0;
`endif

endmodule
